// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit:
// states, opcodes, funct codes, ULA operations and mux select codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDI_EX = 4'd9,
    S_ADDI_WB = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NONE  = 2'b11;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PCSRC_RES = 2'b00;
  localparam logic [1:0] PCSRC_OUT = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between the instruction register/datapath (master) and the
// multicycle control unit (slave).
interface mc_control_fsm_if;
  logic       step;
  logic [5:0] OP;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCEn;
  logic       IorD;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic [2:0] ULAControl;
  logic       illegal;
  logic [3:0] state;
  logic [7:0] instr_count;

  modport master (
    output step, OP, Funct, Zero,
    input  PCEn, IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, PCSrc, ULAControl, illegal, state, instr_count
  );

  modport slave (
    input  step, OP, Funct, Zero,
    output PCEn, IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, PCSrc, ULAControl, illegal, state, instr_count
  );
endinterface

// File: rtl/alu_decoder.sv
// Maps ALUOp and the R-type Funct field to a ULA operation code and flags
// Funct values the ULA does not implement.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] i_funct,
  input  logic [1:0] i_alu_op,
  output logic [2:0] o_ula_control,
  output logic       o_funct_illegal
);

  // ULA operation select
  always_comb begin
    o_ula_control   = ULA_ADD;
    o_funct_illegal = 1'b0;
    case (i_alu_op)
      ALUOP_ADD: o_ula_control = ULA_ADD;
      ALUOP_SUB: o_ula_control = ULA_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_ula_control = ULA_ADD;
          FN_SUB:  o_ula_control = ULA_SUB;
          FN_AND:  o_ula_control = ULA_AND;
          FN_OR:   o_ula_control = ULA_OR;
          FN_SLT:  o_ula_control = ULA_SLT;
          default: begin
            o_ula_control   = ULA_ADD;
            o_funct_illegal = 1'b1;
          end
        endcase
      end
      // Idle states drive the all-zero code
      default: o_ula_control = 3'b000;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle Moore control FSM for the 8-bit MIPS-subset datapath.
// Optional retired-instruction counter enabled by `define MC_INSTR_COUNT_EN.
module mc_control_fsm
  import mc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  mc_control_fsm_if.slave    bus
);

  state_t     r_state;
  state_t     w_next;
  logic       w_op_illegal;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_iord;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_regdst;
  logic       w_memtoreg;
  logic       w_regwrite;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_pcsrc;
  logic [1:0] w_alu_op;
  logic [2:0] w_ula_control;
  logic       w_funct_illegal;
  logic       w_illegal;

  alu_decoder u_alu_decoder (
    .i_funct         (bus.Funct),
    .i_alu_op        (w_alu_op),
    .o_ula_control   (w_ula_control),
    .o_funct_illegal (w_funct_illegal)
  );

  // State register, advanced only on step-qualified edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else if (bus.step) begin
      r_state <= w_next;
    end else begin
      r_state <= r_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next       = S_FETCH;
    w_op_illegal = 1'b0;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (bus.OP)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC_R;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDI_EX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next       = S_FETCH;
            w_op_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR:  w_next = (bus.OP == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = S_MEMWB;
      S_EXEC_R:  w_next = S_ALUWB;
      S_ADDI_EX: w_next = S_ADDI_WB;
      default:   w_next = S_FETCH;
    endcase
  end

  // Per-state control decode
  always_comb begin
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_iord     = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = SRCB_B;
    w_pcsrc    = PCSRC_RES;
    w_alu_op   = ALUOP_NONE;
    case (r_state)
      S_FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        w_alusrcb = SRCB_ONE;
        w_alu_op  = ALUOP_ADD;
      end
      S_DECODE: begin
        w_alusrcb = SRCB_IMM;
        w_alu_op  = ALUOP_ADD;
      end
      S_MEMADR, S_ADDI_EX: begin
        w_alusrca = 1'b1;
        w_alusrcb = SRCB_IMM;
        w_alu_op  = ALUOP_ADD;
      end
      S_MEMRD:  w_iord = 1'b1;
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
      end
      S_EXEC_R: begin
        w_alusrca = 1'b1;
        w_alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_ADDI_WB: w_regwrite = 1'b1;
      S_BRANCH: begin
        w_alusrca = 1'b1;
        w_branch  = 1'b1;
        w_alu_op  = ALUOP_SUB;
        w_pcsrc   = PCSRC_OUT;
      end
      S_JUMP: begin
        w_pcwrite = 1'b1;
        w_pcsrc   = PCSRC_JMP;
      end
      default: w_alu_op = ALUOP_NONE;
    endcase
  end

  assign w_illegal = ((r_state == S_DECODE) & w_op_illegal) |
                     ((r_state == S_EXEC_R) & w_funct_illegal);

  // Write-type strobes are gated by reset so nothing commits while it is held
  assign bus.PCEn       = rst & (w_pcwrite | (w_branch & bus.Zero));
  assign bus.IorD       = w_iord;
  assign bus.IRWrite    = rst & w_irwrite;
  assign bus.MemWrite   = rst & w_memwrite;
  assign bus.RegDst     = w_regdst;
  assign bus.MemtoReg   = w_memtoreg;
  assign bus.RegWrite   = rst & w_regwrite;
  assign bus.ALUSrcA    = w_alusrca;
  assign bus.ALUSrcB    = w_alusrcb;
  assign bus.PCSrc      = w_pcsrc;
  assign bus.ULAControl = w_ula_control;
  assign bus.illegal    = rst & w_illegal;
  assign bus.state      = r_state;

`ifdef MC_INSTR_COUNT_EN
  logic [7:0] r_instr_count;
  logic       w_retire;

  assign w_retire = bus.step & (w_next == S_FETCH) &
                    ((r_state == S_MEMWB)   | (r_state == S_MEMWR) |
                     (r_state == S_ALUWB)   | (r_state == S_ADDI_WB) |
                     (r_state == S_BRANCH)  | (r_state == S_JUMP));

  // Retired-instruction counter, wraps naturally at 8 bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instr_count <= 8'h00;
    end else if (w_retire) begin
      r_instr_count <= r_instr_count + 8'h01;
    end else begin
      r_instr_count <= r_instr_count;
    end
  end

  assign bus.instr_count = r_instr_count;
`else
  assign bus.instr_count = 8'h00;
`endif

endmodule
